// File: rtl/vend_controller_if.sv
// vend_controller_if: coin/button inputs and actuator/hopper outputs of the vend controller
interface vend_controller_if;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       select;
    logic       cancel;
    logic [7:0] credit;
    logic       dispense;
    logic       change_pulse;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       busy;
    modport master (
        output coin_valid, coin_value, select, cancel,
        input  credit, dispense, change_pulse, change_amount, coin_reject, busy
    );
    modport slave (
        input  coin_valid, coin_value, select, cancel,
        output credit, dispense, change_pulse, change_amount, coin_reject, busy
    );
endinterface

// File: rtl/vend_controller.sv
// vend_controller: coin credit, vend/refund sequencing and tick-based dispense/timeout timing
module vend_controller #(
    parameter int unsigned TICK_DIV       = 62500,
    parameter int unsigned PRICE          = 75,
    parameter int unsigned MAX_CREDIT     = 200,
    parameter int unsigned DISPENSE_TICKS = 4000,
    parameter int unsigned TIMEOUT_TICKS  = 20000
) (
    input logic              Clock_in,
    input logic              Reset,
    vend_controller_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] CHANGE   = 2'd3;
    localparam int unsigned TMAX = DISPENSE_TICKS > TIMEOUT_TICKS ? DISPENSE_TICKS : TIMEOUT_TICKS;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TMAX + 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    credit_q, credit_d, chg_q, chg_d, amount_q, amount_d;
    logic          dispense_q, dispense_d, pulse_q, pulse_d, reject_q, reject_d, busy_q, busy_d;
    logic [7:0]    coin_cents;
    logic [8:0]    sum;
    logic          fits, in_coll, act_cancel, act_select, coin_ok, tick, timeout, disp_done, restart;

    always_comb begin
        coin_cents = bus.coin_value == 2'd0 ? 8'd5 :
                     bus.coin_value == 2'd1 ? 8'd10 :
                     bus.coin_value == 2'd2 ? 8'd25 : 8'd100;
        sum        = {1'b0, credit_q} + {1'b0, coin_cents};
        fits       = sum <= 9'(MAX_CREDIT);
        in_coll    = state_q == COLLECT;
        act_cancel = in_coll && bus.cancel;
        act_select = in_coll && bus.select && !bus.cancel && credit_q >= 8'(PRICE);
        // a coin only counts when no button wins the cycle
        coin_ok    = bus.coin_valid && fits &&
                     (state_q == IDLE || (in_coll && !act_cancel && !act_select));
        tick       = pre_q == PW'(TICK_DIV - 1);
        timeout    = in_coll && tick && tcnt_q == TW'(TIMEOUT_TICKS - 1) && !coin_ok;
        disp_done  = state_q == DISPENSE && tick && tcnt_q == TW'(DISPENSE_TICKS - 1);
        state_d    = state_q == IDLE    ? (coin_ok ? COLLECT : IDLE) :
                     state_q == COLLECT ? (act_cancel || timeout ? CHANGE : act_select ? DISPENSE : COLLECT) :
                     state_q == DISPENSE ? (disp_done ? (chg_q != 8'd0 ? CHANGE : IDLE) : DISPENSE) :
                     IDLE;
        chg_d      = act_select ? credit_q - 8'(PRICE) :
                     act_cancel || timeout ? credit_q : chg_q;
        // restarting on entry and on each accepted coin keeps intervals phase-exact
        restart    = state_d != state_q || coin_ok;
        pre_d      = restart || tick ? '0 : pre_q + 1'b1;
        tcnt_d     = restart ? '0 : tcnt_q + TW'(tick);
        credit_d   = state_d == IDLE ? 8'd0 : coin_ok ? sum[7:0] : credit_q;
        dispense_d = state_d == DISPENSE;
        pulse_d    = state_d == CHANGE;
        amount_d   = state_d == CHANGE ? chg_d : 8'd0;
        busy_d     = state_d == DISPENSE || state_d == CHANGE;
        reject_d   = bus.coin_valid && !coin_ok;
    end

    always_ff @(posedge Clock_in) begin
        if (Reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            tcnt_q     <= '0;
            credit_q   <= 8'd0;
            chg_q      <= 8'd0;
            amount_q   <= 8'd0;
            dispense_q <= 1'b0;
            pulse_q    <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tcnt_q     <= tcnt_d;
            credit_q   <= credit_d;
            chg_q      <= chg_d;
            amount_q   <= amount_d;
            dispense_q <= dispense_d;
            pulse_q    <= pulse_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.credit        = credit_q;
    assign bus.dispense      = dispense_q;
    assign bus.change_pulse  = pulse_q;
    assign bus.change_amount = amount_q;
    assign bus.coin_reject   = reject_q;
    assign bus.busy          = busy_q;
endmodule

// File: doc/vend_controller.md
# vend_controller

Top-level sequencer for the soda machine. It accumulates coin credit, decides when a vend may start, times the dispense and idle-timeout intervals from an internal tick prescaler, and issues a one-shot change/refund. It sits between the coin acceptor and select/cancel buttons on one side and the dispense actuator and change hopper on the other. All timing derives from `Clock_in` through one shared prescaler.

## Interface
- `TICK_DIV`, default 62500: `Clock_in` cycles per timer tick (2 kHz at 125 MHz).
- `PRICE`, default 75: vend price in cents.
- `MAX_CREDIT`, default 200: maximum credit accepted.
- `DISPENSE_TICKS`, default 4000: length of the dispense pulse in ticks (2 s).
- `TIMEOUT_TICKS`, default 20000: idle time in COLLECT before auto-refund (10 s).
- `Clock_in`  in  1  system clock; the only clock in the block.
- `Reset`  in  1  synchronous, active-high reset.
- `coin_valid`  in  1  single-cycle pulse: a coin is present.
- `coin_value`  in  2  coin code, sampled with `coin_valid`: 00=5, 01=10, 10=25, 11=100 cents.
- `select`  in  1  vend request, level (debounced upstream).
- `cancel`  in  1  refund request, level (debounced upstream).
- `credit`  out  8  current credit in cents.
- `dispense`  out  1  actuator drive; high for the whole DISPENSE state.
- `change_pulse`  out  1  single-cycle strobe to the hopper.
- `change_amount`  out  8  amount to pay out; valid while `change_pulse` is high, 0 otherwise.
- `coin_reject`  out  1  single-cycle strobe: coin diverted to the return chute.
- `busy`  out  1  high in DISPENSE and CHANGE.

## Operation
- Reset, sampled on a `Clock_in` rising edge, forces:
  - state to IDLE;
  - prescaler and tick counter to 0;
  - every output to 0.
- Reset mid-dispense drops `dispense` on the next edge. Credit is discarded and no refund is issued.
- Input priority in any one cycle: `cancel` > `select` > `coin_valid`.
  - A coin that arrives in the same cycle as an acted-upon `cancel` or `select` is rejected.
- States:
  - **IDLE**: `credit`=0.
    - Coin accepted → COLLECT, `credit` = coin value.
    - `select` and `cancel` are ignored.
  - **COLLECT**
    - Coin: if `credit` + value ≤ `MAX_CREDIT`, add it and restart the timeout. Otherwise pulse `coin_reject` and leave `credit` unchanged.
    - `select` with `credit` ≥ `PRICE` → DISPENSE, latching change = `credit` − `PRICE`.
    - `select` with `credit` < `PRICE` is ignored.
    - `cancel` → CHANGE, latching change = `credit`.
    - `TIMEOUT_TICKS` ticks with no accepted coin → CHANGE, latching change = `credit`.
  - **DISPENSE**: `dispense`=1; every coin is rejected; `select` and `cancel` are ignored.
    - After `DISPENSE_TICKS` ticks → CHANGE if the latched change > 0, else IDLE.
  - **CHANGE** (exactly one cycle):
    - `change_pulse`=1 and `change_amount` = latched change.
    - `credit` clears on the next edge, then → IDLE.
    - Coins arriving in this cycle are rejected.
- Prescaler:
  - Counts 0..`TICK_DIV`−1 and emits an internal tick on terminal count.
  - Clears, together with the tick counter, on every state entry and on every accepted coin in COLLECT.
  - This makes interval lengths exact and independent of phase.
- Width rules:
  - Credit arithmetic uses a 9-bit sum before the `MAX_CREDIT` compare; it never wraps.
  - The tick counter is sized for max(`DISPENSE_TICKS`, `TIMEOUT_TICKS`).
  - Change is always ≤ `MAX_CREDIT` − `PRICE` for a vend and ≤ `MAX_CREDIT` for a refund.

## Timing
- All outputs are registered; a response appears on the edge after the causing input is sampled.
- An accepted coin updates `credit` 1 cycle after `coin_valid`.
- `dispense` rises 1 cycle after `select` is sampled. It stays high for exactly `DISPENSE_TICKS`×`TICK_DIV` cycles.
- `change_pulse` fires:
  - on the cycle immediately following the last dispense cycle; or
  - 1 cycle after `cancel`; or
  - `TIMEOUT_TICKS`×`TICK_DIV` cycles after the last accepted coin.
- `coin_reject` is high 1 cycle after the rejected `coin_valid`.
- `busy` tracks the state with the same one-cycle latency as `dispense`.

## Test plan
Run with `TICK_DIV`=4, `DISPENSE_TICKS`=3, `TIMEOUT_TICKS`=5, `PRICE`=75, `MAX_CREDIT`=200.
- Exact vend: coins 25, 25, 25, then `select` → `credit`=75. `dispense` is high for 12 cycles. No `change_pulse`; back in IDLE with `credit`=0.
- Overpay: coins 100, 10, then `select` → 12-cycle dispense. `change_pulse` on the next cycle with `change_amount`=35.
- Cancel and timeout:
  - Coin 10, then `cancel` → `change_pulse` 1 cycle later with `change_amount`=10.
  - Coin 5 and wait → `change_pulse` (5) exactly 20 cycles after the accepted coin.
- Rejects:
  - Coins 100, 100, then 5 → third coin gets `coin_reject`; `credit` stays 200.
  - A coin during DISPENSE is rejected.
  - A coin in the same cycle as `cancel` is rejected, and the refund excludes it.
- Reset mid-dispense: assert `Reset` for 1 cycle at dispense cycle 5 → next edge `dispense`=0 and `credit`=0. No `change_pulse` afterwards.
